mult_booth: RTL
===============

Name: mult_booth

Overview:
- Sequential signed 32x32 multiplier for the MIPS-subset datapath; it executes mult and writes the 64-bit product to Hi/Lo.
- Companion to the sequential divider: same Start/Fim handshake toward the control unit and same Hi/Lo result convention, but the inverse operation.
- Uses radix-2 Booth recoding, one recoded bit per clock.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH wide, split into Hi (upper) and Lo (lower).

Ports:
- Clk  input  1  clock; all state updates on the negative edge, matching the datapath.
- Reset  input  1  asynchronous, active-low reset; Reset=0 clears all state immediately.
- MultA  input  WIDTH  multiplicand (two's complement), sampled on the start edge only.
- MultB  input  WIDTH  multiplier (two's complement), sampled on the start edge only.
- MultStart  input  1  start request, level-sensitive, honoured only in IDLE.
- MultBusy  output  1  high in RUN and DONE.
- MultFim  output  1  one-cycle completion pulse; Hi/Lo are valid while it is high.
- Hi  output  WIDTH  product[2*WIDTH-1:WIDTH].
- Lo  output  WIDTH  product[WIDTH-1:0].

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE; Hi=0, Lo=0, MultFim=0, MultBusy=0.
  - Internal registers A, Q, Q_1 and count are cleared.
  - A reset mid-operation abandons the operation; Hi/Lo are not updated with partial results.
- Registers:
  - A is WIDTH+1 bits, sign-extended, so the operation cannot overflow when MultA=-2^(WIDTH-1).
  - M is WIDTH+1 bits, sign-extended copy of MultA.
  - Q is WIDTH bits; Q_1 is 1 bit; count is $clog2(WIDTH+2) bits.
- IDLE:
  - If MultStart=1 on an edge: M={MultA[WIDTH-1],MultA}, Q=MultB, A=0, Q_1=0, count=0; go to RUN.
  - Otherwise hold. Hi/Lo keep their last result.
- RUN, each edge:
  - Select the addend from {Q[0],Q_1}:
    - 01: A+M
    - 10: A-M
    - 00 or 11: A
  - Arithmetic right shift of {A',Q,Q_1} by 1.
  - count++.
  - When count reaches STEPS-1 (the last step), in the same edge: Hi/Lo take the post-shift {A[WIDTH-1:0],Q}, MultFim=1, go to DONE.
- STEPS: WIDTH in signed mode, WIDTH+1 in unsigned mode (see Optional Feature).
- DONE: next edge sets MultFim=0 and goes to IDLE.
  - MultStart high in DONE is ignored; it is accepted on the following edge (IDLE).
- Latency:
  - Start sampled at edge E0.
  - MultFim rises at edge E0+STEPS and falls at E0+STEPS+1.
  - Back-to-back throughput: one product per STEPS+2 edges.
- Operand changes after E0 have no effect.
- MultStart during RUN/DONE is ignored; no queuing.
- Zero operands need no special case (the loop yields 0). This block has no exception output.

Optional Feature:
- Macro: MULT_UNSIGNED_EN.
- Defined:
  - Adds input MultUnsigned (1 bit), sampled at E0.
  - When MultUnsigned=1 (multu), M and Q are zero-extended to WIDTH+1 bits, the Q/shift path is one bit wider, STEPS=WIDTH+1, and Hi/Lo hold the unsigned product.
  - When MultUnsigned=0, behaviour is identical to the signed mode.
- Not defined: the port is absent, the mode is signed only, and STEPS=WIDTH.

Decomposition:
- Shared package (mult_pkg):
  - State enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Booth recode constants BOOTH_ADD=2'b01 and BOOTH_SUB=2'b10.
  - Default WIDTH localparam.
- One natural sub-module: booth_step. It is purely combinational: A, M, Q, Q_1 in; shifted A, Q, Q_1 out. The top level holds the FSM, count and the Hi/Lo registers.

Test Plan:
1. MultA=7, MultB=-3 (0xFFFFFFFD), MultStart pulsed at E0 -> MultFim high exactly at edge E0+32 for one cycle; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; MultBusy high from E0+1 through E0+33.
2. MultA=MultB=0x80000000 -> Hi=0x40000000, Lo=0x00000000, with no overflow corruption.
3. MultA=MultB=0xFFFFFFFF -> signed: Hi=0, Lo=1. With MULT_UNSIGNED_EN and MultUnsigned=1: Hi=0xFFFFFFFE, Lo=0x00000001, and MultFim at E0+33.
4. Start 0x1234*0x10; pulse MultStart again at E0+5 with different operands; change MultA at E0+1 -> the second start and the operand change are ignored; Hi=0, Lo=0x12340; exactly one MultFim.
5. Complete 3*5 (Hi=0, Lo=15). Then start 100*100 and drive Reset=0 at E0+10 between edges -> Hi=0, Lo=0, MultBusy=0, MultFim=0 immediately. After release, 2*2 gives Lo=4 with nominal latency.
6. MultA=0, MultB=0xDEADBEEF, then MultStart held high continuously -> Hi=0, Lo=0; the next operation is accepted at the edge after DONE. Each MultFim pulse is separated by STEPS+2 edges.

Source files
------------

// File: rtl/mult_pkg.sv
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and constants for the sequential Booth
//                multiplier (FSM state encoding, Booth recode pairs,
//                default operand width).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // {Q[0], Q_1} pairs that require an add or a subtract of M.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/booth_step.sv
// ============================================================================
//  Module      : booth_step
//  Description : One radix-2 Booth iteration, purely combinational.
//                Chooses A, A+M or A-M from {Q[0],Q_1}, then arithmetically
//                shifts {A,Q,Q_1} right by one bit.
//  Ports       : A_i  [AW-1:0]  partial product (upper part)
//                M_i  [AW-1:0]  sign/zero-extended multiplicand
//                Q_i  [QW-1:0]  multiplier / low product bits
//                Q1_i           previously shifted-out multiplier bit
//                A_o, Q_o, Q1_o shifted results
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_step
  import mult_pkg::*;
#(
  parameter int AW = 33,
  parameter int QW = 32
) (
  input  logic [AW-1:0] A_i,
  input  logic [AW-1:0] M_i,
  input  logic [QW-1:0] Q_i,
  input  logic          Q1_i,
  output logic [AW-1:0] A_o,
  output logic [QW-1:0] Q_o,
  output logic          Q1_o
);

  logic [AW-1:0] w_sum;

  always_comb begin
    w_sum = A_i;
    case ({Q_i[0], Q1_i})
      BOOTH_ADD: w_sum = A_i + M_i;
      BOOTH_SUB: w_sum = A_i - M_i;
      default:   w_sum = A_i;
    endcase
    // Arithmetic right shift: the sign of the new A is replicated at the top.
    {A_o, Q_o, Q1_o} = {w_sum[AW-1], w_sum, Q_i};
  end

endmodule

`default_nettype wire

// File: rtl/mult_booth.sv
// ============================================================================
//  Module      : mult_booth
//  Description : Sequential signed WIDTHxWIDTH radix-2 Booth multiplier with
//                Start/Fim handshake. One recoded bit per negative clock
//                edge; 2*WIDTH-bit product delivered on Hi/Lo.
//  Ports       : Clk          clock (state changes on the falling edge)
//                Reset        asynchronous active-low reset
//                MultA/MultB  operands, sampled on the accepting edge only
//                MultStart    start request, honoured in IDLE
//                MultUnsigned unsigned-mode select (MULT_UNSIGNED_EN only)
//                MultBusy     high while RUN or DONE
//                MultFim      one-cycle completion pulse
//                Hi/Lo        upper/lower half of the last product
//  Options     : MULT_UNSIGNED_EN - adds MultUnsigned (multu support)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_booth
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] MultA,
  input  logic [WIDTH-1:0] MultB,
  input  logic             MultStart,
`ifdef MULT_UNSIGNED_EN
  input  logic             MultUnsigned,
`endif
  output logic             MultBusy,
  output logic             MultFim,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int AW = WIDTH + 1;
`ifdef MULT_UNSIGNED_EN
  // One extra multiplier bit so a zero-extended operand fits.
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  state_t          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [AW-1:0]   m_q, m_d;
  logic [QW-1:0]   q_q, q_d;
  logic            q1_q, q1_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
`ifdef MULT_UNSIGNED_EN
  logic            uns_q, uns_d;
`endif

  logic [AW-1:0]   a_sh;
  logic [QW-1:0]   q_sh;
  logic            q1_sh;
  logic [CW-1:0]   last_cnt;

  booth_step #(
    .AW (AW),
    .QW (QW)
  ) u_step (
    .A_i  (a_q),
    .M_i  (m_q),
    .Q_i  (q_q),
    .Q1_i (q1_q),
    .A_o  (a_sh),
    .Q_o  (q_sh),
    .Q1_o (q1_sh)
  );

`ifdef MULT_UNSIGNED_EN
  assign last_cnt = uns_q ? CW'(WIDTH) : CW'(WIDTH - 1);
`else
  assign last_cnt = CW'(WIDTH - 1);
`endif

  always_ff @(negedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULT_UNSIGNED_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULT_UNSIGNED_EN
      uns_q   <= uns_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULT_UNSIGNED_EN
    uns_d   = uns_q;
`endif

    case (state_q)
      IDLE: begin
        if (MultStart) begin
`ifdef MULT_UNSIGNED_EN
          uns_d = MultUnsigned;
          if (MultUnsigned) begin
            m_d = {1'b0, MultA};
            q_d = {1'b0, MultB};
          end else begin
            m_d = {MultA[WIDTH-1], MultA};
            q_d = {MultB[WIDTH-1], MultB};
          end
`else
          m_d = {MultA[WIDTH-1], MultA};
          q_d = MultB;
`endif
          a_d     = '0;
          q1_d    = 1'b0;
          count_d = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d     = a_sh;
        q_d     = q_sh;
        q1_d    = q1_sh;
        count_d = count_q + CW'(1);
        if (count_q == last_cnt) begin
`ifdef MULT_UNSIGNED_EN
          if (uns_q) begin
            // WIDTH+1 shifts: the whole Q register holds low product bits.
            hi_d = {a_sh[WIDTH-2:0], q_sh[WIDTH]};
            lo_d = q_sh[WIDTH-1:0];
          end else begin
            // Only WIDTH shifts: Q[0] still holds the unused extension bit.
            hi_d = a_sh[WIDTH-1:0];
            lo_d = q_sh[WIDTH:1];
          end
`else
          hi_d = a_sh[WIDTH-1:0];
          lo_d = q_sh;
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign MultBusy = (state_q != IDLE);
  assign MultFim  = (state_q == DONE);
  assign Hi       = hi_q;
  assign Lo       = lo_q;

endmodule

`default_nettype wire
